// File: rtl/spk_out_arb.sv
// Spike-out FIFO push arbiter: merges N soma spike lanes and the config write path
// into one registered push port, with one-deep holding registers and almost-full backpressure.
module spk_out_arb #(
  parameter int N   = 4,
  parameter int FW  = 59,
  parameter int FTW = 3,
  parameter int SW  = 24,
  parameter int CW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    lane_fire,
  input  logic [N*SW-1:0] lane_neuid,
  output logic [N-1:0]    lane_busy,
  input  logic            cfg_we,
  input  logic [FW-1:0]   cfg_wdata,
  output logic            cfg_busy,
  input  logic            fifo_full,
  output logic            push,
  output logic [FW-1:0]   push_data,
  output logic [N-1:0]    ovf,
  input  logic            ovf_clr,
  output logic [CW-1:0]   spk_cnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    pend_v_reg, pend_v_next;
  logic [SW-1:0]   pend_id_reg [N];
  logic            cfg_v_reg, cfg_v_next;
  logic [FW-1:0]   cfg_d_reg;
  logic [PW-1:0]   ptr_reg;
  logic            push_reg;
  logic [FW-1:0]   push_data_reg;
  logic [N-1:0]    ovf_reg, ovf_next;
  logic [CW-1:0]   spk_cnt_reg;

  logic            grant_cfg;
  logic [N-1:0]    grant_lane;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic            lane_found;
  logic [N-1:0]    lane_accept;
  logic            cfg_accept;
  logic [FW-1:0]   lane_flit;

  // Config has strict priority; lanes are searched round-robin starting after ptr.
  always_comb begin
    grant_cfg  = !fifo_full && cfg_v_reg;
    grant_lane = '0;
    grant_idx  = ptr_reg;
    cand       = '0;
    lane_found = 1'b0;
    if (!fifo_full && !cfg_v_reg) begin
      for (int k = 1; k <= N; k++) begin
        cand = PW'((int'(ptr_reg) + k) % N);
        if (!lane_found && pend_v_reg[cand]) begin
          lane_found = 1'b1;
          grant_idx  = cand;
        end
      end
    end
    if (lane_found) grant_lane[grant_idx] = 1'b1;
  end

  // A request is taken when the slot is free or is being emptied by this cycle's grant.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane_accept[gi] = lane_fire[gi] && (!pend_v_reg[gi] || grant_lane[gi]);
      assign pend_v_next[gi] = lane_accept[gi] || (pend_v_reg[gi] && !grant_lane[gi]);
      assign ovf_next[gi]    = (lane_fire[gi] && !lane_accept[gi]) || (ovf_reg[gi] && !ovf_clr);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_id_reg[gi] <= '0;
        end else if (lane_accept[gi]) begin
          pend_id_reg[gi] <= lane_neuid[gi*SW +: SW];
        end
      end
    end
  endgenerate

  assign cfg_accept = cfg_we && (!cfg_v_reg || grant_cfg);
  assign cfg_v_next = cfg_accept || (cfg_v_reg && !grant_cfg);
  assign lane_flit  = {{FTW{1'b0}}, {(FW-FTW-SW){1'b0}}, pend_id_reg[grant_idx]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_reg    <= '0;
      cfg_v_reg     <= 1'b0;
      cfg_d_reg     <= '0;
      ptr_reg       <= PW'(N - 1);
      push_reg      <= 1'b0;
      push_data_reg <= '0;
      ovf_reg       <= '0;
      spk_cnt_reg   <= '0;
    end else begin
      pend_v_reg <= pend_v_next;
      cfg_v_reg  <= cfg_v_next;
      ovf_reg    <= ovf_next;
      push_reg   <= grant_cfg || lane_found;
      if (cfg_accept) cfg_d_reg <= cfg_wdata;
      if (grant_cfg) begin
        push_data_reg <= cfg_d_reg;
      end else if (lane_found) begin
        push_data_reg <= lane_flit;
        ptr_reg       <= grant_idx;
        spk_cnt_reg   <= spk_cnt_reg + CW'(1);
      end
    end
  end

  assign lane_busy = pend_v_reg;
  assign cfg_busy  = cfg_v_reg;
  assign push      = push_reg;
  assign push_data = push_data_reg;
  assign ovf       = ovf_reg;
  assign spk_cnt   = spk_cnt_reg;
endmodule
